// File: rtl/tape_punch.sv
// Behavioural G-15 paper-tape punch: paces the computer with PUNCH_SYNC and records punched frames.
// Optional PUNCH_TRACE_EN: per-frame $display, overflow warning and hex dump of the tape at $finish.
module tape_punch #(
    parameter int CHAR_PERIOD_MS = 60,
    parameter int SPINUP_MS      = 100,
    parameter int SYNC_CLKS      = 4,
    parameter int SAMPLE_CLKS    = 20,
    parameter int DEPTH          = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       PUNCH_SIGNAL,
    input  logic                       PUNCHED_TAPE1,
    input  logic                       PUNCHED_TAPE2,
    input  logic                       PUNCHED_TAPE3,
    input  logic                       PUNCHED_TAPE4,
    input  logic                       PUNCHED_TAPE5,
    output logic                       PUNCH_SYNC,
    output logic                       frame_valid,
    output logic [4:0]                 frame_code,
    output logic [$clog2(DEPTH+1)-1:0] frame_count,
    output logic                       overflow,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [4:0]                 rd_data
);
    localparam int CW     = $clog2(DEPTH + 1);
    localparam int AW     = $clog2(DEPTH);
    localparam int MS_MAX = (SPINUP_MS > CHAR_PERIOD_MS) ? SPINUP_MS : CHAR_PERIOD_MS;
    localparam int CK_MAX = (SYNC_CLKS > SAMPLE_CLKS) ? SYNC_CLKS : SAMPLE_CLKS;
    localparam int MW     = $clog2(MS_MAX + 1);
    localparam int KW     = $clog2(CK_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, SPINUP, SYNC, SETTLE, SAMPLE, GAP} state_t;

    state_t        state_q, state_d;
    logic [MW-1:0] ms_cnt;
    logic [KW-1:0] clk_cnt;
    logic          stop_q;
    logic          capture;
    logic          wr_en;
    logic [4:0]    code;
    logic [4:0]    mem [DEPTH];

    assign code  = {PUNCHED_TAPE5, PUNCHED_TAPE4, PUNCHED_TAPE3, PUNCHED_TAPE2, PUNCHED_TAPE1};
    assign wr_en = capture && !rst && (frame_count < DEPTH_C);

    // The sample is taken on the edge that enters SAMPLE, so frame_valid is high during SAMPLE.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            IDLE:   if (PUNCH_SIGNAL) state_d = SPINUP;
            SPINUP: begin
                if (!PUNCH_SIGNAL)                   state_d = IDLE;
                else if (tick && ms_cnt <= MW'(1))   state_d = SYNC;
            end
            SYNC:   if (clk_cnt <= KW'(1)) state_d = SETTLE;
            SETTLE: begin
                if (clk_cnt <= KW'(1)) begin
                    state_d = SAMPLE;
                    capture = 1'b1;
                end
            end
            SAMPLE: state_d = (stop_q || !PUNCH_SIGNAL) ? IDLE : GAP;
            GAP: begin
                if (!PUNCH_SIGNAL)                   state_d = IDLE;
                else if (tick && ms_cnt <= MW'(1))   state_d = SYNC;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ms_cnt      <= '0;
            clk_cnt     <= '0;
            stop_q      <= 1'b0;
            PUNCH_SYNC  <= 1'b0;
            frame_valid <= 1'b0;
            frame_code  <= '0;
            frame_count <= '0;
            overflow    <= 1'b0;
        end else begin
            state_q     <= state_d;
            PUNCH_SYNC  <= (state_d == SYNC);
            frame_valid <= capture;

            // Counters load on state entry; a tick in the loading clk is deliberately dropped.
            if (state_q != state_d) begin
                case (state_d)
                    SPINUP:  ms_cnt  <= MW'(SPINUP_MS);
                    GAP:     ms_cnt  <= MW'(CHAR_PERIOD_MS);
                    SYNC:    clk_cnt <= KW'(SYNC_CLKS);
                    SETTLE:  clk_cnt <= KW'(SAMPLE_CLKS);
                    default: ;
                endcase
            end else if ((state_q == SPINUP || state_q == GAP) && tick) begin
                ms_cnt <= ms_cnt - MW'(1);
            end else if (state_q == SYNC || state_q == SETTLE) begin
                clk_cnt <= clk_cnt - KW'(1);
            end

            // A drop during SYNC/SETTLE is remembered so the frame finishes, then the punch stops.
            if (state_d == SYNC && state_q != SYNC)
                stop_q <= 1'b0;
            else if (!PUNCH_SIGNAL && (state_q == SYNC || state_q == SETTLE))
                stop_q <= 1'b1;

            if (capture) begin
                frame_code <= code;
                if (frame_count < DEPTH_C) frame_count <= frame_count + CW'(1);
                else                       overflow    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[frame_count[AW-1:0]] <= code;
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

`ifdef PUNCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            if (frame_count < DEPTH_C)
                $display("%0t tape_punch: frame %0d code %o", $time, frame_count, code);
            else if (!overflow)
                $display("%0t tape_punch: warning, tape buffer full, frame dropped", $time);
        end
    end

    final begin
        for (int unsigned i = 0; i < int'(frame_count); i++) $display("%h", mem[i]);
    end
`else
    // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_tape_punch.sv
// Self-checking bench for tape_punch: directed sequence with randomized codes and tick spacing,
// checked against a queue-based tape model.
module tb_tape_punch;
    localparam int CHAR  = 12;
    localparam int SPIN  = 20;
    localparam int SYNCW = 4;
    localparam int SAMP  = 20;
    localparam int DA    = 64;
    localparam int DB    = 4;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, pa = 1'b0, pb = 1'b0;
    logic [4:0] code = '0;

    logic       a_sync, a_fv, a_ovf;
    logic [4:0] a_fc, a_rdata;
    logic [6:0] a_cnt;
    logic [5:0] a_raddr = '0;
    logic       b_sync, b_fv, b_ovf;
    logic [4:0] b_fc, b_rdata;
    logic [2:0] b_cnt;
    logic [1:0] b_raddr = '0;

    tape_punch #(.CHAR_PERIOD_MS(CHAR), .SPINUP_MS(SPIN), .SYNC_CLKS(SYNCW),
                 .SAMPLE_CLKS(SAMP), .DEPTH(DA)) dut_a (
        .clk(clk), .rst(rst), .tick(tick), .PUNCH_SIGNAL(pa),
        .PUNCHED_TAPE1(code[0]), .PUNCHED_TAPE2(code[1]), .PUNCHED_TAPE3(code[2]),
        .PUNCHED_TAPE4(code[3]), .PUNCHED_TAPE5(code[4]),
        .PUNCH_SYNC(a_sync), .frame_valid(a_fv), .frame_code(a_fc), .frame_count(a_cnt),
        .overflow(a_ovf), .rd_addr(a_raddr), .rd_data(a_rdata));

    tape_punch #(.CHAR_PERIOD_MS(CHAR), .SPINUP_MS(SPIN), .SYNC_CLKS(SYNCW),
                 .SAMPLE_CLKS(SAMP), .DEPTH(DB)) dut_b (
        .clk(clk), .rst(rst), .tick(tick), .PUNCH_SIGNAL(pb),
        .PUNCHED_TAPE1(code[0]), .PUNCHED_TAPE2(code[1]), .PUNCHED_TAPE3(code[2]),
        .PUNCHED_TAPE4(code[3]), .PUNCHED_TAPE5(code[4]),
        .PUNCH_SYNC(b_sync), .frame_valid(b_fv), .frame_code(b_fc), .frame_count(b_cnt),
        .overflow(b_ovf), .rd_addr(b_raddr), .rd_data(b_rdata));

    always #5 clk = ~clk;

    // Tick spacing exceeds the SYNC+SETTLE+SAMPLE span, so no tick falls in the uncounted window.
    initial begin
        forever begin
            repeat ($urandom_range(36, 27) - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    int ticks_seen = 0;
    always @(posedge clk) if (tick === 1'b1) ticks_seen++;

    logic       sel = 1'b0;
    logic       sync_m, fv_m, ovf_m;
    logic [4:0] fc_m;
    logic [6:0] cnt_m;
    assign sync_m = sel ? b_sync : a_sync;
    assign fv_m   = sel ? b_fv   : a_fv;
    assign ovf_m  = sel ? b_ovf  : a_ovf;
    assign fc_m   = sel ? b_fc   : a_fc;
    assign cnt_m  = sel ? {4'b0, b_cnt} : a_cnt;

    logic [4:0] exp_a[$];
    logic [4:0] exp_b[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_punch(input logic v);
        if (sel) pb = v; else pa = v;
    endtask

    task automatic watch_ticks(input int k, output int seen);
        int target, n;
        target = ticks_seen + k;
        n = 0;
        seen = 0;
        while (ticks_seen < target && n < k * 40 + 10) begin
            step();
            n++;
            if (sync_m === 1'b1 || fv_m === 1'b1) seen++;
        end
        check("tick_wait_bound", ticks_seen >= target, 1);
    endtask

    task automatic read_back(input int i, output logic [4:0] d);
        if (sel) b_raddr = 2'(i); else a_raddr = 6'(i);
        step();
        d = sel ? b_rdata : a_rdata;
    endtask

    // One complete frame: code changes right after the sync rises; drop_at >= 0 releases
    // the punch request that many clks after the sync was first seen.
    task automatic punch_frame(input logic [4:0] c, input int drop_at, output int st);
        int n, sz, depth;
        n = 0;
        while (sync_m !== 1'b1 && n < 4000) begin step(); n++; end
        check("sync_timeout", n < 4000, 1);
        st = ticks_seen;
        code = c;
        n = 0;
        while (sync_m === 1'b1 && n < 50) begin
            if (n == drop_at) set_punch(1'b0);
            step();
            n++;
        end
        check("sync_width", n, SYNCW);
        n = 0;
        while (fv_m !== 1'b1 && n < 100) begin step(); n++; end
        check("sample_delay", n, SAMP);
        check("frame_code", fc_m, c);
        if (sel) exp_b.push_back(c); else exp_a.push_back(c);
        depth = sel ? DB : DA;
        sz    = sel ? exp_b.size() : exp_a.size();
        check("frame_count", cnt_m, (sz < depth) ? sz : depth);
        check("overflow", ovf_m, sz > depth);
        step();
        check("frame_valid_width", fv_m, 0);
    endtask

    initial begin
        int st, prev, t0, n, s1, s2, d_sp;
        logic [4:0] d, c;

        repeat (3) step();
        check("rst_sync", a_sync, 0);
        check("rst_fv", a_fv, 0);
        check("rst_fcode", a_fc, 0);
        check("rst_count", a_cnt, 0);
        check("rst_ovf", a_ovf, 0);
        check("rst_rdata", a_rdata, 0);
        check("rst_count_b", b_cnt, 0);
        check("rst_ovf_b", b_ovf, 0);
        rst = 1'b0;
        step();

        // Reset while the first sync is high
        pa = 1'b1;
        step();
        t0 = ticks_seen;
        n = 0;
        while (a_sync !== 1'b1 && n < 4000) begin step(); n++; end
        check("spinup_ticks_pre_reset", ticks_seen - t0, SPIN);
        rst = 1'b1;
        step();
        check("midsync_rst_sync", a_sync, 0);
        check("midsync_rst_count", a_cnt, 0);
        rst = 1'b0;
        step();
        t0 = ticks_seen;

        // Fresh spin-up and first frame
        code = 5'h15;
        punch_frame(5'h15, -1, st);
        check("spinup_ticks", st - t0, SPIN);
        read_back(0, d);
        check("rd_addr0", d, 5'h15);

        // Streaming from a clean count: 0x00..0x1F, then random codes
        pa = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_a.delete();
        pa = 1'b1;
        prev = 0;
        for (int i = 0; i < 38; i++) begin
            c = (i < 32) ? i[4:0] : 5'($urandom);
            punch_frame(c, -1, st);
            if (i > 0) begin
                d_sp = st - prev;
                check("sync_spacing", (d_sp >= CHAR - 1) && (d_sp <= CHAR + 1), 1);
            end
            prev = st;
        end

        // Drop two clks into SYNC: frame still stored, no further sync
        punch_frame(5'($urandom), 1, st);
        watch_ticks(CHAR + 3, s1);
        check("no_sync_after_sync_drop", s1, 0);
        check("count_after_sync_drop", a_cnt, exp_a.size());

        // Re-raise (count continues), then drop during GAP
        pa = 1'b1;
        punch_frame(5'($urandom), -1, st);
        watch_ticks(3, s1);
        pa = 1'b0;
        watch_ticks(CHAR + 3, s2);
        check("no_frame_after_gap_drop", s1 + s2, 0);
        check("count_after_gap_drop", a_cnt, exp_a.size());

        // Abort during spin-up
        pa = 1'b1;
        watch_ticks(SPIN / 2, s1);
        pa = 1'b0;
        watch_ticks(SPIN + 3, s2);
        check("no_sync_spinup_abort", s1 + s2, 0);
        check("count_after_abort", a_cnt, exp_a.size());

        for (int i = 0; i < exp_a.size(); i++) begin
            read_back(i, d);
            check("tape_a", d, exp_a[i]);
        end

        // Overflow on the 4-deep instance
        sel = 1'b1;
        pb = 1'b1;
        for (int k = 0; k < 6; k++) punch_frame(5'($urandom), -1, st);
        pb = 1'b0;
        step();
        check("ovf_final_count", b_cnt, DB);
        check("ovf_final_flag", b_ovf, 1);
        for (int i = 0; i < DB; i++) begin
            read_back(i, d);
            check("tape_b", d, exp_b[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
